// File: rtl/npu_cmd_seq_if.sv
// Host command stream and NPU register bus seen by the command sequencer.
// master = host/NPU side, slave = sequencer side.
interface npu_cmd_seq_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [7:0]  CMD_ADR;
    logic [31:0] CMD_WDATA;
    logic        CMD_KICK;
    logic        ABORT;
    logic [7:0]  NPU_ADR;
    logic        NPU_WR;
    logic [31:0] NPU_WDATA;
    logic        NPU_INT;
    logic        BUSY;
    logic        DONE;
    logic [15:0] DONE_CNT;
    logic        TIMEOUT;

    modport master (
        output CMD_VALID, CMD_ADR, CMD_WDATA, CMD_KICK, ABORT, NPU_INT,
        input  CMD_READY, NPU_ADR, NPU_WR, NPU_WDATA,
        input  BUSY, DONE, DONE_CNT, TIMEOUT
    );

    modport slave (
        input  CMD_VALID, CMD_ADR, CMD_WDATA, CMD_KICK, ABORT, NPU_INT,
        output CMD_READY, NPU_ADR, NPU_WR, NPU_WDATA,
        output BUSY, DONE, DONE_CNT, TIMEOUT
    );
endinterface

// File: rtl/npu_cmd_seq.sv
// Buffers host register writes, replays them on the NPU bus and, after a
// kick write, waits for NPU_INT, acknowledges it and counts finished jobs.
module npu_cmd_seq #(
    parameter int          DEPTH       = 8,
    parameter int          TIMEOUT_CYC = 4096,
    parameter logic [7:0]  INT_CLR_ADR = 8'h01,
    parameter logic [31:0] INT_CLR_VAL = 32'h0000_0000
) (
    input logic           CLK,
    input logic           RESET_X,
    npu_cmd_seq_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_INT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [40:0]   mem [DEPTH];
    logic [40:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   wait_cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          cmd_ready;
    logic          busy;
    logic          int_hit;
    logic          tmo_hit;
    logic          to_err;
    logic          flush;
    logic          npu_wr;
    logic [7:0]    npu_adr;
    logic [31:0]   npu_wdata;
    logic          done;
    logic [15:0]   done_cnt;
    logic          timeout;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push    = bus.CMD_VALID & cmd_ready;
    // The kick write cycle and the one after it never sample NPU_INT.
    assign int_hit = (state == WAIT_INT) & (wait_cnt >= 16'd2) &
                     bus.NPU_INT & ~bus.ABORT;
    assign tmo_hit = (state == WAIT_INT) &
                     (wait_cnt == 16'(TIMEOUT_CYC - 1));
    assign to_err  = (state == WAIT_INT) & (state_nx == ERR);
    assign flush   = bus.ABORT | to_err;

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (pop && head[40]) state_nx = WAIT_INT;
            WAIT_INT: begin
                if (int_hit)      state_nx = IDLE;
                else if (tmo_hit) state_nx = ERR;
            end
            ERR:      state_nx = ERR;
            default:  state_nx = IDLE;
        endcase
        if (bus.ABORT) state_nx = IDLE;
    end

    always_comb begin
        cmd_ready = RESET_X & ~full & (state != ERR) & ~bus.ABORT;
        pop       = (state == IDLE) & ~empty & ~bus.ABORT;
        busy      = (state != IDLE) | ~empty | npu_wr;
    end

    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wr_ptr] <= {bus.CMD_KICK, bus.CMD_ADR, bus.CMD_WDATA};
    end

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            wait_cnt <= '0;
        end else if (bus.ABORT) begin
            wait_cnt <= '0;
        end else if (pop && head[40]) begin
            wait_cnt <= '0;
        end else if (state == WAIT_INT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            npu_wr    <= 1'b0;
            npu_adr   <= '0;
            npu_wdata <= '0;
            done      <= 1'b0;
            done_cnt  <= '0;
            timeout   <= 1'b0;
        end else if (bus.ABORT) begin
            npu_wr  <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            npu_wr <= 1'b0;
            done   <= 1'b0;
            if (int_hit) begin
                npu_wr    <= 1'b1;
                npu_adr   <= INT_CLR_ADR;
                npu_wdata <= INT_CLR_VAL;
                done      <= 1'b1;
                done_cnt  <= done_cnt + 16'd1;
            end else if (pop) begin
                npu_wr    <= 1'b1;
                npu_adr   <= head[39:32];
                npu_wdata <= head[31:0];
            end
            if (to_err) timeout <= 1'b1;
        end
    end

    assign bus.CMD_READY = cmd_ready;
    assign bus.BUSY      = busy;
    assign bus.NPU_WR    = npu_wr;
    assign bus.NPU_ADR   = npu_adr;
    assign bus.NPU_WDATA = npu_wdata;
    assign bus.DONE      = done;
    assign bus.DONE_CNT  = done_cnt;
    assign bus.TIMEOUT   = timeout;
endmodule

// File: tb/tb_npu_cmd_seq.sv
// Directed bench for npu_cmd_seq: vector table for streaming and a kick job,
// then hand-written fill, timeout, INT-on-timeout and reset sequences.
module tb_npu_cmd_seq;
    logic clk = 1'b0;
    logic rst_x = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    npu_cmd_seq_if bus ();

    npu_cmd_seq #(
        .DEPTH       (8),
        .TIMEOUT_CYC (16),
        .INT_CLR_ADR (8'h01),
        .INT_CLR_VAL (32'h0)
    ) dut (
        .CLK     (clk),
        .RESET_X (rst_x),
        .bus     (bus)
    );

    typedef struct {
        logic        v;
        logic [7:0]  adr;
        logic [31:0] wd;
        logic        kick;
        logic        irq;
        logic        e_wr;
        logic [7:0]  e_adr;
        logic [31:0] e_wd;
        logic        e_done;
        logic        e_busy;
        logic        e_rdy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vec [22];

    function automatic vec_t mk(
        input logic v, input logic [7:0] adr, input logic [31:0] wd,
        input logic kick, input logic irq,
        input logic e_wr, input logic [7:0] e_adr, input logic [31:0] e_wd,
        input logic e_done, input logic e_busy, input logic e_rdy,
        input logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.adr = adr; r.wd = wd; r.kick = kick; r.irq = irq;
        r.e_wr = e_wr; r.e_adr = e_adr; r.e_wd = e_wd;
        r.e_done = e_done; r.e_busy = e_busy; r.e_rdy = e_rdy;
        r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in;
        bus.CMD_VALID = 1'b0;
        bus.CMD_KICK  = 1'b0;
        bus.ABORT     = 1'b0;
        bus.NPU_INT   = 1'b0;
    endtask

    initial begin
        vec[0]  = mk(1, 8'h10, 32'hA, 0, 0, 0, 8'h00, 32'h0, 0, 0, 1, 0);
        vec[1]  = mk(1, 8'h11, 32'hB, 0, 0, 0, 8'h00, 32'h0, 0, 1, 1, 0);
        vec[2]  = mk(1, 8'h12, 32'hC, 0, 0, 1, 8'h10, 32'hA, 0, 1, 1, 0);
        vec[3]  = mk(0, 8'h00, 32'h0, 0, 0, 1, 8'h11, 32'hB, 0, 1, 1, 0);
        vec[4]  = mk(0, 8'h00, 32'h0, 0, 0, 1, 8'h12, 32'hC, 0, 1, 1, 0);
        vec[5]  = mk(0, 8'h00, 32'h0, 0, 0, 0, 8'h12, 32'hC, 0, 0, 1, 0);
        vec[6]  = mk(1, 8'h20, 32'h5, 0, 0, 0, 8'h12, 32'hC, 0, 0, 1, 0);
        vec[7]  = mk(1, 8'h00, 32'h1, 1, 0, 0, 8'h12, 32'hC, 0, 1, 1, 0);
        vec[8]  = mk(0, 8'h00, 32'h0, 0, 0, 1, 8'h20, 32'h5, 0, 1, 1, 0);
        vec[9]  = mk(0, 8'h00, 32'h0, 0, 0, 1, 8'h00, 32'h1, 0, 1, 1, 0);
        for (int i = 10; i < 19; i++)
            vec[i] = mk(0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h1, 0, 1, 1, 0);
        vec[19] = mk(0, 8'h00, 32'h0, 0, 1, 0, 8'h00, 32'h1, 0, 1, 1, 0);
        vec[20] = mk(0, 8'h00, 32'h0, 0, 0, 1, 8'h01, 32'h0, 1, 1, 1, 1);
        vec[21] = mk(0, 8'h00, 32'h0, 0, 0, 0, 8'h01, 32'h0, 0, 0, 1, 1);

        idle_in();
        bus.CMD_ADR   = 8'h00;
        bus.CMD_WDATA = 32'h0;
        nxt();
        nxt();
        #1;
        chk("rst_ready", bus.CMD_READY, 0);
        chk("rst_wr", bus.NPU_WR, 0);
        chk("rst_adr", bus.NPU_ADR, 0);
        chk("rst_wdata", bus.NPU_WDATA, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_cnt", bus.DONE_CNT, 0);
        chk("rst_tmo", bus.TIMEOUT, 0);
        @(negedge clk);
        rst_x = 1'b1;

        // Streaming writes, then write + kick with INT 10 cycles later
        for (int i = 0; i < 22; i++) begin
            bus.CMD_VALID = vec[i].v;
            bus.CMD_ADR   = vec[i].adr;
            bus.CMD_WDATA = vec[i].wd;
            bus.CMD_KICK  = vec[i].kick;
            bus.NPU_INT   = vec[i].irq;
            #1;
            chk($sformatf("row%0d_wr", i), bus.NPU_WR, vec[i].e_wr);
            chk($sformatf("row%0d_adr", i), bus.NPU_ADR, vec[i].e_adr);
            chk($sformatf("row%0d_wd", i), bus.NPU_WDATA, vec[i].e_wd);
            chk($sformatf("row%0d_done", i), bus.DONE, vec[i].e_done);
            chk($sformatf("row%0d_busy", i), bus.BUSY, vec[i].e_busy);
            chk($sformatf("row%0d_rdy", i), bus.CMD_READY, vec[i].e_rdy);
            chk($sformatf("row%0d_cnt", i), bus.DONE_CNT, vec[i].e_cnt);
            nxt();
        end
        idle_in();

        // Fill all 8 entries behind a pending kick, 9th push refused
        bus.CMD_VALID = 1; bus.CMD_ADR = 8'h30;
        bus.CMD_WDATA = 32'h7; bus.CMD_KICK = 1;
        nxt();
        idle_in();
        nxt();
        #1;
        chk("fill_kick_wr", bus.NPU_WR, 1);
        chk("fill_kick_adr", bus.NPU_ADR, 8'h30);
        for (int i = 0; i < 8; i++) begin
            bus.CMD_VALID = 1;
            bus.CMD_ADR   = 8'h40 + 8'(i);
            bus.CMD_WDATA = 32'h100 + 32'(i);
            #1;
            chk($sformatf("fill_rdy%0d", i), bus.CMD_READY, 1);
            nxt();
        end
        bus.CMD_ADR = 8'h99; bus.CMD_WDATA = 32'h999;
        #1;
        chk("fill_full_rdy", bus.CMD_READY, 0);
        nxt();
        bus.CMD_VALID = 0;
        bus.NPU_INT   = 1;
        nxt();
        bus.NPU_INT = 0;
        #1;
        chk("fill_ack_wr", bus.NPU_WR, 1);
        chk("fill_ack_adr", bus.NPU_ADR, 8'h01);
        chk("fill_ack_done", bus.DONE, 1);
        chk("fill_ack_cnt", bus.DONE_CNT, 2);
        for (int i = 0; i < 8; i++) begin
            nxt();
            #1;
            chk($sformatf("drain%0d_wr", i), bus.NPU_WR, 1);
            chk($sformatf("drain%0d_adr", i), bus.NPU_ADR, 8'h40 + 8'(i));
            chk($sformatf("drain%0d_wd", i), bus.NPU_WDATA, 32'h100 + 32'(i));
        end
        nxt();
        #1;
        chk("drain_end_wr", bus.NPU_WR, 0);
        chk("drain_end_busy", bus.BUSY, 0);

        // Timeout with two entries queued behind the kick
        bus.CMD_VALID = 1; bus.CMD_ADR = 8'h50;
        bus.CMD_WDATA = 32'h9; bus.CMD_KICK = 1;
        nxt();
        bus.CMD_ADR = 8'h51; bus.CMD_KICK = 0;
        nxt();
        #1;
        chk("tmo_kick_adr", bus.NPU_ADR, 8'h50);
        bus.CMD_ADR = 8'h52;
        nxt();
        bus.CMD_VALID = 0;
        for (int i = 1; i < 15; i++) nxt();
        #1;
        chk("tmo_before", bus.TIMEOUT, 0);
        nxt();
        #1;
        chk("tmo_flag", bus.TIMEOUT, 1);
        chk("tmo_rdy", bus.CMD_READY, 0);
        chk("tmo_wr", bus.NPU_WR, 0);
        nxt();
        #1;
        chk("err_wr", bus.NPU_WR, 0);
        chk("err_busy", bus.BUSY, 1);
        bus.ABORT = 1; bus.CMD_VALID = 1; bus.CMD_ADR = 8'h60;
        #1;
        chk("abort_rdy", bus.CMD_READY, 0);
        nxt();
        idle_in();
        #1;
        chk("abort_tmo", bus.TIMEOUT, 0);
        chk("abort_rdy_after", bus.CMD_READY, 1);
        chk("abort_busy", bus.BUSY, 0);
        chk("abort_cnt", bus.DONE_CNT, 2);
        nxt();
        #1;
        chk("abort_flushed_wr", bus.NPU_WR, 0);

        // INT on the exact timeout cycle wins
        bus.CMD_VALID = 1; bus.CMD_ADR = 8'h70;
        bus.CMD_WDATA = 32'h3; bus.CMD_KICK = 1;
        nxt();
        idle_in();
        nxt();
        for (int i = 0; i < 15; i++) nxt();
        bus.NPU_INT = 1;
        nxt();
        bus.NPU_INT = 0;
        #1;
        chk("edge_ack_wr", bus.NPU_WR, 1);
        chk("edge_ack_adr", bus.NPU_ADR, 8'h01);
        chk("edge_done", bus.DONE, 1);
        chk("edge_tmo", bus.TIMEOUT, 0);
        chk("edge_cnt", bus.DONE_CNT, 3);
        nxt();
        #1;
        chk("edge_tmo_after", bus.TIMEOUT, 0);
        chk("edge_busy", bus.BUSY, 0);

        // Reset during WAIT_INT with FIFO half full
        bus.CMD_VALID = 1; bus.CMD_ADR = 8'h80;
        bus.CMD_WDATA = 32'h8; bus.CMD_KICK = 1;
        nxt();
        bus.CMD_KICK = 0;
        for (int i = 0; i < 4; i++) begin
            bus.CMD_ADR = 8'h81 + 8'(i);
            nxt();
        end
        idle_in();
        rst_x = 1'b0;
        #1;
        chk("mrst_wr", bus.NPU_WR, 0);
        chk("mrst_adr", bus.NPU_ADR, 0);
        chk("mrst_wd", bus.NPU_WDATA, 0);
        chk("mrst_cnt", bus.DONE_CNT, 0);
        chk("mrst_busy", bus.BUSY, 0);
        chk("mrst_rdy", bus.CMD_READY, 0);
        nxt();
        rst_x = 1'b1;
        bus.NPU_INT = 1;
        for (int i = 0; i < 5; i++) begin
            nxt();
            #1;
            chk($sformatf("mrst_post%0d_wr", i), bus.NPU_WR, 0);
            chk($sformatf("mrst_post%0d_busy", i), bus.BUSY, 0);
        end
        chk("mrst_post_rdy", bus.CMD_READY, 1);
        bus.NPU_INT = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
